// File: rtl/mdu_pkg.sv
// Purpose : shared opcode and state encodings for the multiply/divide unit.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package mdu_pkg;

  // E-stage MDU opcode encoding (5-bit field from the decoder).
  localparam logic [4:0] MDU_DEFAULT = 5'd0;
  localparam logic [4:0] MDU_MULT    = 5'd1;
  localparam logic [4:0] MDU_MULTU   = 5'd2;
  localparam logic [4:0] MDU_DIV     = 5'd3;
  localparam logic [4:0] MDU_DIVU    = 5'd4;
  localparam logic [4:0] MDU_MTLO    = 5'd5;
  localparam logic [4:0] MDU_MTHI    = 5'd6;
  localparam logic [4:0] MDU_MFLO    = 5'd7;
  localparam logic [4:0] MDU_MFHI    = 5'd8;

  typedef enum logic {
    MDU_S_IDLE = 1'b0,
    MDU_S_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Purpose : combinational 64-bit result for mult/multu/div/divu, incl. divide-by-zero rule.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; result is consumed by mdu_ctrl only on an accepted start.
// Ports   : i_op opcode, i_a/i_b operands; o_hi/o_lo result halves;
//           o_wr = 0 when the commit must leave HI/LO untouched.
// Config  : MDU_DIVZERO_HOLD_EN defined -> divide by zero keeps HI/LO;
//           undefined -> divide by zero yields HI=A, LO=all ones.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_wr
);

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] prod;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    sgn   = (i_op == MDU_MULT) || (i_op == MDU_DIV);
    // A 64x64 product truncated to 64 bits is exact for both signed and
    // unsigned 32-bit operands once they are extended accordingly.
    a64   = {{32{sgn & i_a[31]}}, i_a};
    b64   = {{32{sgn & i_b[31]}}, i_b};
    prod  = a64 * b64;

    // Signed divide runs on magnitudes through a single unsigned divider;
    // 0x8000_0000 has magnitude 0x8000_0000 which still fits unsigned.
    a_neg = sgn & i_a[31];
    b_neg = sgn & i_b[31];
    ua    = a_neg ? (32'd0 - i_a) : i_a;
    ub    = b_neg ? (32'd0 - i_b) : i_b;
    if (ub == 32'd0) begin
      uq = 32'd0;
      ur = 32'd0;
    end else begin
      uq = ua / ub;
      ur = ua % ub;
    end

    o_hi = prod[63:32];
    o_lo = prod[31:0];
    o_wr = 1'b1;
    if ((i_op == MDU_DIV) || (i_op == MDU_DIVU)) begin
      if (i_b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
        o_wr = 1'b0;
`else
        o_hi = i_a;
        o_lo = 32'hFFFF_FFFF;
`endif
      end else begin
        // Quotient truncates toward zero; remainder takes the dividend's sign.
        o_lo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        o_hi = a_neg ? (32'd0 - ur) : ur;
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Purpose : EX-stage MDU controller: HI/LO ownership, multi-cycle sequencing, mt/mf, D-stage stall.
// Latency : MULT_CYCLES / DIV_CYCLES from start edge to HI/LO commit; mf reads are combinational.
// Backpressure: o_stall holds D while an op is in flight or starting; starts/mt during BUSY are dropped.
// Ports   : i_clk/i_rst_n clock and async active-low reset; i_mduOp, i_mdu_start, i_A, i_B
//           from E stage; i_req CP0 cancel; i_D_mdu D-stage MDU use; o_busy, o_stall,
//           o_result (mf value), o_HI/o_LO debug.
// Config  : MDU_DIVZERO_HOLD_EN selects the divide-by-zero behaviour (see mdu_arith).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_mduOp,
  input  logic        i_mdu_start,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic        i_req,
  input  logic        i_D_mdu,
  output logic        o_busy,
  output logic        o_stall,
  output logic [31:0] o_result,
  output logic [31:0] o_HI,
  output logic [31:0] o_LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic             wr_q, wr_d;

  logic [31:0]      ar_hi, ar_lo;
  logic             ar_wr;
  logic             is_md, is_div, start_ok;

  mdu_arith u_arith (
    .i_op (i_mduOp),
    .i_a  (i_A),
    .i_b  (i_B),
    .o_hi (ar_hi),
    .o_lo (ar_lo),
    .o_wr (ar_wr)
  );

  always_comb begin
    is_div   = (i_mduOp == MDU_DIV) || (i_mduOp == MDU_DIVU);
    is_md    = is_div || (i_mduOp == MDU_MULT) || (i_mduOp == MDU_MULTU);
    start_ok = (state_q == MDU_S_IDLE) && i_mdu_start && !i_req && is_md;

    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    wr_d     = wr_q;

    case (state_q)
      MDU_S_IDLE: begin
        if (start_ok) begin
          // Result is computed up front; the busy window only models latency.
          hi_tmp_d = ar_hi;
          lo_tmp_d = ar_lo;
          wr_d     = ar_wr;
          cnt_d    = is_div ? DIV_LAT : MULT_LAT;
          state_d  = MDU_S_BUSY;
        end else if (!i_req && (i_mduOp == MDU_MTHI)) begin
          hi_d = i_A;
        end else if (!i_req && (i_mduOp == MDU_MTLO)) begin
          lo_d = i_A;
        end
      end
      MDU_S_BUSY: begin
        // i_req is deliberately ignored here: an in-flight op always commits.
        if (cnt_q == CNT_ONE) begin
          cnt_d   = '0;
          state_d = MDU_S_IDLE;
          if (wr_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = MDU_S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= MDU_S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      wr_q     <= wr_d;
    end
  end

  always_comb begin
    o_busy   = (state_q == MDU_S_BUSY);
    // i_mdu_start covers the start cycle, before the registered busy rises.
    o_stall  = i_D_mdu & (o_busy | i_mdu_start);
    o_HI     = hi_q;
    o_LO     = lo_q;
    o_result = 32'd0;
    if (i_mduOp == MDU_MFHI) o_result = hi_q;
    else if (i_mduOp == MDU_MFLO) o_result = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Purpose : directed self-checking bench for mdu_ctrl (default parameters).
// Latency : checks 5-cycle mult and 10-cycle div windows.
// Backpressure: checks o_stall across start and busy cycles.
module tb_mdu_ctrl;

  localparam logic [4:0] OP_DEF   = 5'd0;
  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MTLO  = 5'd5;
  localparam logic [4:0] OP_MTHI  = 5'd6;
  localparam logic [4:0] OP_MFLO  = 5'd7;
  localparam logic [4:0] OP_MFHI  = 5'd8;

  logic        i_clk;
  logic        i_rst_n;
  logic [4:0]  i_mduOp;
  logic        i_mdu_start;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic        i_req;
  logic        i_D_mdu;
  logic        o_busy;
  logic        o_stall;
  logic [31:0] o_result;
  logic [31:0] o_HI;
  logic [31:0] o_LO;

  int vectors = 0;
  int errs    = 0;

  mdu_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_mduOp     (i_mduOp),
    .i_mdu_start (i_mdu_start),
    .i_A         (i_A),
    .i_B         (i_B),
    .i_req       (i_req),
    .i_D_mdu     (i_D_mdu),
    .o_busy      (o_busy),
    .o_stall     (o_stall),
    .o_result    (o_result),
    .o_HI        (o_HI),
    .o_LO        (o_LO)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    i_mduOp     = op;
    i_mdu_start = 1'b1;
    i_A         = a;
    i_B         = b;
    tick();
    i_mdu_start = 1'b0;
    i_mduOp     = OP_DEF;
  endtask

  // Counts cycles with o_busy high, bounded.
  task automatic wait_busy(output int n);
    n = 0;
    while (o_busy === 1'b1 && n < 60) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int st;
    i_rst_n = 1'b0; i_mduOp = OP_DEF; i_mdu_start = 1'b0;
    i_A = '0; i_B = '0; i_req = 1'b0; i_D_mdu = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy",   {31'd0, o_busy},  32'd0);
    chk("rst_stall",  {31'd0, o_stall}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_hi",     o_HI, 32'd0);
    chk("rst_lo",     o_LO, 32'd0);
    i_rst_n = 1'b1;
    tick();

    // Reset mid-BUSY: no commit of 2*3
    start_op(OP_MULT, 32'd2, 32'd3);
    tick();
    chk("midrst_busy_before", {31'd0, o_busy}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_hi",   o_HI, 32'd0);
    chk("midrst_lo",   o_LO, 32'd0);
    tick();
    i_rst_n = 1'b1;
    repeat (6) tick();
    chk("postrst_busy", {31'd0, o_busy}, 32'd0);
    chk("postrst_lo",   o_LO, 32'd0);

    // Signed mult -2*3
    start_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_busy(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", o_HI, 32'hFFFF_FFFF);
    chk("mult_lo", o_LO, 32'hFFFF_FFFA);
    // Back-to-back: started in the first cycle busy is low
    start_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_busy(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", o_HI, 32'd2);
    chk("multu_lo", o_LO, 32'hFFFF_FFFA);

    // Signed / unsigned divide
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_busy(n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", o_LO, 32'hFFFF_FFFD);
    chk("div_hi", o_HI, 32'hFFFF_FFFF);
    start_op(OP_DIVU, 32'd7, 32'd2);
    wait_busy(n);
    chk("divu_lo", o_LO, 32'd3);
    chk("divu_hi", o_HI, 32'd1);

    // Stall: div 100/7 while D holds mflo
    i_D_mdu = 1'b1;
    i_mduOp = OP_DIV; i_mdu_start = 1'b1; i_A = 32'd100; i_B = 32'd7;
    #1;
    chk("stall_start_cycle", {31'd0, o_stall}, 32'd1);
    chk("busy_start_cycle",  {31'd0, o_busy},  32'd0);
    tick();
    i_mdu_start = 1'b0; i_mduOp = OP_DEF;
    n = 0; st = 0;
    while (o_busy === 1'b1 && n < 60) begin
      n++;
      if (o_stall === 1'b1) st++;
      tick();
    end
    chk("stall_busy_cycles", st, 32'd10);
    chk("stall_after", {31'd0, o_stall}, 32'd0);
    i_D_mdu = 1'b0;
    i_mduOp = OP_MFLO; #1;
    chk("mflo_quot", o_result, 32'd14);
    i_mduOp = OP_MFHI; #1;
    chk("mfhi_rem", o_result, 32'd2);
    i_mduOp = OP_DEF; #1;
    chk("mf_default", o_result, 32'd0);

    // Exception cancels the start
    i_req = 1'b1;
    start_op(OP_MULT, 32'd5, 32'd5);
    i_req = 1'b0;
    chk("cancel_busy", {31'd0, o_busy}, 32'd0);
    chk("cancel_hi", o_HI, 32'd2);
    chk("cancel_lo", o_LO, 32'd14);

    // Exception mid-flight, start and mthi during BUSY all ignored
    start_op(OP_MULT, 32'd4, 32'd5);
    n = 0;
    while (o_busy === 1'b1 && n < 60) begin
      n++;
      i_req = 1'b0; i_mdu_start = 1'b0; i_mduOp = OP_DEF;
      if (n == 2) begin i_mdu_start = 1'b1; i_mduOp = OP_DIV; i_A = 32'd9; i_B = 32'd3; end
      if (n == 3) i_req = 1'b1;
      if (n == 4) begin i_mduOp = OP_MTHI; i_A = 32'h0000_DEAD; end
      tick();
    end
    i_req = 1'b0; i_mdu_start = 1'b0; i_mduOp = OP_DEF;
    chk("req_mid_cycles", n, 32'd5);
    chk("req_mid_lo", o_LO, 32'd20);
    chk("req_mid_hi", o_HI, 32'd0);
    tick();
    chk("busy_start_ignored", {31'd0, o_busy}, 32'd0);

    // mtX, and mtX suppressed by i_req
    i_mduOp = OP_MTHI; i_A = 32'd1; tick();
    i_mduOp = OP_MFHI; #1;
    chk("mthi_next_cycle", o_result, 32'd1);
    i_mduOp = OP_MTLO; i_A = 32'd2; tick();
    i_mduOp = OP_DEF;
    chk("mtlo", o_LO, 32'd2);
    i_mduOp = OP_MTHI; i_A = 32'd77; i_req = 1'b1; tick();
    i_mduOp = OP_DEF; i_req = 1'b0;
    chk("mthi_req_hi", o_HI, 32'd1);

    // Divide by zero
    start_op(OP_DIV, 32'd5, 32'd0);
    wait_busy(n);
    chk("dz_cycles", n, 32'd10);
`ifdef MDU_DIVZERO_HOLD_EN
    chk("dz_hi", o_HI, 32'd1);
    chk("dz_lo", o_LO, 32'd2);
`else
    chk("dz_hi", o_HI, 32'd5);
    chk("dz_lo", o_LO, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
